// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// slave  : the arbiter's side (takes commands and memory read data, drives ready/rsp/memory).
// master : the environment's side (requesters plus the memory).
interface mem_arbiter_if #(
  parameter int BITS   = 16,
  parameter int ADDR_W = 8
);
  logic              i_req0_valid;
  logic              i_req0_rw;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [BITS-1:0]   i_req0_data;
  logic              o_req0_ready;
  logic              o_rsp0_valid;
  logic [BITS-1:0]   o_rsp0_data;

  logic              i_req1_valid;
  logic              i_req1_rw;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [BITS-1:0]   i_req1_data;
  logic              o_req1_ready;
  logic              o_rsp1_valid;
  logic [BITS-1:0]   o_rsp1_data;

  logic              o_mem_rw;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [BITS-1:0]   o_mem_data;
  logic [BITS-1:0]   i_mem_data;

  modport slave (
    input  i_req0_valid, i_req0_rw, i_req0_addr, i_req0_data,
    input  i_req1_valid, i_req1_rw, i_req1_addr, i_req1_data,
    input  i_mem_data,
    output o_req0_ready, o_rsp0_valid, o_rsp0_data,
    output o_req1_ready, o_rsp1_valid, o_rsp1_data,
    output o_mem_rw, o_mem_addr, o_mem_data
  );

  modport master (
    output i_req0_valid, i_req0_rw, i_req0_addr, i_req0_data,
    output i_req1_valid, i_req1_rw, i_req1_addr, i_req1_data,
    output i_mem_data,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_data,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_data,
    input  o_mem_rw, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port data memory.
// Pipeline: combinational grant -> stage A (drives memory for one cycle)
// -> stage R (registered response to the originating requester).
// Fixed 2-cycle accept-to-response latency, one access per cycle, never stalls.
// Optional feature macro ARB_ROUND_ROBIN_EN: round-robin contention resolution;
// when undefined, requester 0 has fixed priority.
module mem_arbiter #(
  parameter int BITS   = 16,
  parameter int ADDR_W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mem_arbiter_if.slave bus
);

  logic gnt0, gnt1, acc;

  logic              a_vld_q, a_vld_d;
  logic              a_id_q, a_id_d;
  logic              a_rw_q, a_rw_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [BITS-1:0]   a_data_q, a_data_d;

  logic              rsp0_vld_q, rsp0_vld_d;
  logic              rsp1_vld_q, rsp1_vld_d;
  logic [BITS-1:0]   rsp0_data_q, rsp0_data_d;
  logic [BITS-1:0]   rsp1_data_q, rsp1_data_d;
  logic [BITS-1:0]   rsp_src;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;

  // Grant: preferred requester wins contention; pointer moves to the one not granted.
  always_comb begin
    gnt0 = bus.i_req0_valid && (!bus.i_req1_valid || !rr_q);
    gnt1 = bus.i_req1_valid && (!bus.i_req0_valid ||  rr_q);
    rr_d = rr_q;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`else
  // Grant: requester 0 always wins contention.
  always_comb begin
    gnt0 = bus.i_req0_valid;
    gnt1 = bus.i_req1_valid && !bus.i_req0_valid;
  end
`endif

  // Ready is the grant itself, forced low while reset is held.
  assign acc              = gnt0 || gnt1;
  assign bus.o_req0_ready = gnt0 && i_rst_n;
  assign bus.o_req1_ready = gnt1 && i_rst_n;

  // Stage A next state: load the granted command, otherwise empty with addr/data held.
  always_comb begin
    a_vld_d  = acc;
    a_id_d   = a_id_q;
    a_rw_d   = a_rw_q;
    a_addr_d = a_addr_q;
    a_data_d = a_data_q;
    if (gnt0) begin
      a_id_d   = 1'b0;
      a_rw_d   = bus.i_req0_rw;
      a_addr_d = bus.i_req0_addr;
      a_data_d = bus.i_req0_data;
    end else if (gnt1) begin
      a_id_d   = 1'b1;
      a_rw_d   = bus.i_req1_rw;
      a_addr_d = bus.i_req1_addr;
      a_data_d = bus.i_req1_data;
    end
  end

  // Stage R next state: reads return the old memory word, writes echo their data.
  always_comb begin
    rsp_src     = a_rw_q ? a_data_q : bus.i_mem_data;
    rsp0_vld_d  = a_vld_q && !a_id_q;
    rsp1_vld_d  = a_vld_q &&  a_id_q;
    rsp0_data_d = rsp0_vld_d ? rsp_src : rsp0_data_q;
    rsp1_data_d = rsp1_vld_d ? rsp_src : rsp1_data_q;
  end

  // Pipeline registers; reset drops any in-flight command immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_vld_q     <= 1'b0;
      a_id_q      <= 1'b0;
      a_rw_q      <= 1'b0;
      a_addr_q    <= '0;
      a_data_q    <= '0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_id_q      <= a_id_d;
      a_rw_q      <= a_rw_d;
      a_addr_q    <= a_addr_d;
      a_data_q    <= a_data_d;
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign bus.o_mem_rw     = a_vld_q && a_rw_q;
  assign bus.o_mem_addr   = a_addr_q;
  assign bus.o_mem_data   = a_data_q;
  assign bus.o_rsp0_valid = rsp0_vld_q;
  assign bus.o_rsp1_valid = rsp1_vld_q;
  assign bus.o_rsp0_data  = rsp0_data_q;
  assign bus.o_rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and a response scoreboard.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic preload;

  mem_arbiter_if #(.BITS(16), .ADDR_W(8)) bus ();

  mem_arbiter #(.BITS(16), .ADDR_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on rising edge.
  logic [15:0] mem [256];
  assign bus.i_mem_data = mem[bus.o_mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 40 + 5);
    end else if (bus.o_mem_rw) begin
      mem[bus.o_mem_addr] <= bus.o_mem_data;
    end
  end

  typedef struct {
    bit          v;
    bit          id;
    bit          rw;
    logic [7:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t        sb[$];
  logic [15:0] ref_mem [256];
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  bit          last_g0, last_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int csum();
    int s = 0;
    for (int i = 0; i < 256; i++) s += int'(mem[i]) * (i + 1);
    return s;
  endfunction

  task automatic drive(input bit v0, input bit rw0, input logic [7:0] a0, input logic [15:0] d0,
                       input bit v1, input bit rw1, input logic [7:0] a1, input logic [15:0] d1);
    bus.i_req0_valid = v0; bus.i_req0_rw = rw0; bus.i_req0_addr = a0; bus.i_req0_data = d0;
    bus.i_req1_valid = v1; bus.i_req1_rw = rw1; bus.i_req1_addr = a1; bus.i_req1_data = d1;
  endtask

  // One clock: record the grant, push the expected result, then check stage A and the response.
  task automatic tick();
    ent_t e;
    ent_t r;
    e = '{v: 1'b0, id: 1'b0, rw: 1'b0, addr: 8'h00, data: 16'h0000};
    r = e;
    #3;
    last_g0 = bus.i_req0_valid && bus.o_req0_ready;
    last_g1 = bus.i_req1_valid && bus.o_req1_ready;
    check("excl_grant", {31'b0, last_g0 && last_g1}, 32'd0);
    if (last_g0) begin
      e.v = 1'b1; e.id = 1'b0; e.rw = bus.i_req0_rw; e.addr = bus.i_req0_addr; e.data = bus.i_req0_data;
    end else if (last_g1) begin
      e.v = 1'b1; e.id = 1'b1; e.rw = bus.i_req1_rw; e.addr = bus.i_req1_addr; e.data = bus.i_req1_data;
    end
    if (e.v) begin
      if (e.rw) ref_mem[e.addr] = e.data;
      else      e.data = ref_mem[e.addr];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("mem_rw", {31'b0, bus.o_mem_rw}, {31'b0, e.v && e.rw});
    if (e.v) check("mem_addr", {24'b0, bus.o_mem_addr}, {24'b0, e.addr});
    if (e.v && e.rw) check("mem_data", {16'b0, bus.o_mem_data}, {16'b0, e.data});
    if (sb.size() > 1) r = sb.pop_front();
    check("rsp0_valid", {31'b0, bus.o_rsp0_valid}, {31'b0, r.v && !r.id});
    check("rsp1_valid", {31'b0, bus.o_rsp1_valid}, {31'b0, r.v &&  r.id});
    if (r.v && !r.id) check("rsp0_data", {16'b0, bus.o_rsp0_data}, {16'b0, r.data});
    if (r.v &&  r.id) check("rsp1_data", {16'b0, bus.o_rsp1_data}, {16'b0, r.data});
    if (bus.o_rsp0_valid || bus.o_rsp1_valid) pulses++;
  endtask

  initial begin
    int          p0, p1, cs0;
    bit          exp_g0, exp_g1;
    logic [15:0] old10;

    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 40 + 5);

    // Power-on reset with a requester already asking: ready must stay low.
    rst_n   = 1'b0;
    preload = 1'b1;
    drive(1'b1, 1'b0, 8'h01, 16'h0, 1'b1, 1'b0, 8'h02, 16'h0);
    #2;
    check("rst_ready0", {31'b0, bus.o_req0_ready}, 32'd0);
    check("rst_ready1", {31'b0, bus.o_req1_ready}, 32'd0);
    check("rst_outs", {bus.o_mem_rw, bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_mem_addr, 21'b0}, 32'd0);
    check("rst_data", {bus.o_mem_data, bus.o_rsp0_data}, 32'd0);
    check("rst_rsp1d", {16'b0, bus.o_rsp1_data}, 32'd0);
    @(negedge clk);
    preload = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read from requester 0.
    drive(1'b1, 1'b0, 8'h03, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    check("rd_ready0", {31'b0, last_g0}, 32'd1);
    check("rd_ready1", {31'b0, last_g1}, 32'd0);
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    tick();

    // Back-to-back write then read of the same address from requester 1.
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 1'b1, 8'h20, 16'hBEEF);
    tick();
    check("wr_grant1", {31'b0, last_g1}, 32'd1);
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 1'b0, 8'h20, 16'h0);
    tick();
    check("rd_grant1", {31'b0, last_g1}, 32'd1);
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    tick();

    // Contention: both requesters valid for four cycles.
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'(p0), 16'h0, 1'b1, 1'b0, 8'(4 + p1), 16'h0);
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_g0 = (k % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      exp_g1 = !exp_g0;
      check($sformatf("cont_g0_%0d", k), {31'b0, last_g0}, {31'b0, exp_g0});
      check($sformatf("cont_g1_%0d", k), {31'b0, last_g1}, {31'b0, exp_g1});
      if (last_g0) p0++;
      if (last_g1) p1++;
    end
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    tick();

    // Idle gap: one read then three idle cycles.
    cs0    = csum();
    pulses = 0;
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b1, 1'b0, 8'hFF, 16'h0);
    tick();
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    tick();
    tick();
    check("idle_pulses", pulses, 32'd1);
    check("idle_csum", csum(), cs0);

    // Reset while a write to 0x10 sits in stage A.
    old10 = 16'(16 * 40 + 5);
    drive(1'b1, 1'b1, 8'h10, 16'h1234, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_memrw", {31'b0, bus.o_mem_rw}, 32'd0);
    check("mid_rst_ready0", {31'b0, bus.o_req0_ready}, 32'd0);
    check("mid_rst_addr", {16'b0, 8'b0, bus.o_mem_addr}, 32'd0);
    check("mid_rst_data", {bus.o_mem_data, bus.o_rsp0_data}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_mem10", {16'b0, mem[8'h10]}, {16'b0, old10});
    check("mid_rst_rsp", {30'b0, bus.o_rsp0_valid, bus.o_rsp1_valid}, 32'd0);
    sb.delete();
    ref_mem[8'h10] = old10;
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Accepting resumes right after reset; the dropped write left 0x10 unchanged.
    drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    check("post_rst_grant", {31'b0, last_g0}, 32'd1);
    drive(1'b0, 1'b0, 8'h0, 16'h0, 1'b0, 1'b0, 8'h0, 16'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 16-bit x 256 data memory.
- Requester 0 is instruction fetch; requester 1 is load/store.
- Accepts at most one command per cycle over valid/ready, registers it, drives the memory port for one cycle, and returns a registered response to the originating requester.
- Fully pipelined: one access per cycle sustained; fixed 2-cycle accept-to-response latency.

Parameters:
- BITS, 16, data width of memory words and request/response data.
- ADDR_W, 8, memory address width.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req0_valid  input  1  requester 0 command valid.
- i_req0_rw  input  1  requester 0 direction: 0 read, 1 write.
- i_req0_addr  input  ADDR_W  requester 0 address.
- i_req0_data  input  BITS  requester 0 write data.
- o_req0_ready  output  1  requester 0 command accepted this cycle.
- o_rsp0_valid  output  1  requester 0 response valid (1-cycle pulse).
- o_rsp0_data  output  BITS  requester 0 response data.
- i_req1_valid, i_req1_rw, i_req1_addr, i_req1_data, o_req1_ready, o_rsp1_valid, o_rsp1_data: same as requester 0, for requester 1.
- o_mem_rw  output  1  memory write enable (high = write).
- o_mem_addr  output  ADDR_W  memory address.
- o_mem_data  output  BITS  memory write data.
- i_mem_data  input  BITS  memory combinational read data for o_mem_addr.

Behaviour:
- Clocking and reset:
  - One clock, i_clk; reset is asynchronous and active-low on i_rst_n.
  - Reset clears all registers immediately, with no clock required. Reset values:
    - o_mem_rw=0, o_mem_addr=0, o_mem_data=0.
    - o_rsp0_valid=0, o_rsp1_valid=0, o_rsp0_data=0, o_rsp1_data=0.
    - Stage-A valid=0, rr pointer=0.
  - o_req*_ready is 0 while i_rst_n=0.
- Stage 0, accept (combinational grant):
  - Exactly one of o_req0_ready/o_req1_ready is high when its valid is high and it wins arbitration; the loser's ready is 0.
  - Ready never depends on downstream state; the pipeline never stalls.
  - A command transfers when valid && ready at a rising edge.
  - A requester keeps valid, rw, addr and data stable until accepted. No retraction check is required.
- Stage A, access (registered):
  - The accepted command is registered into {valid, id, rw, addr, data}.
  - o_mem_addr and o_mem_data come from the stage-A registers.
  - o_mem_rw = stageA.valid && stageA.rw, so the memory writes at the edge ending the access cycle.
  - With stage A empty: o_mem_rw=0, and addr/data hold their last values.
- Stage R, response (registered):
  - At the edge ending the access cycle, if stageA.valid, o_rsp[id]_valid is set to 1 for exactly one cycle.
  - For a read, o_rsp[id]_data = i_mem_data (the old contents); for a write it echoes the written data.
  - The other requester's rsp_valid is 0. Response data holds its last value when valid is 0.
- Latency and ordering:
  - Command accepted at edge N -> memory access during cycle N..N+1 -> o_rsp valid during cycle N+1..N+2.
  - Accesses execute in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data. No forwarding is needed: the write commits before the read's access cycle.
- Arbitration:
  - Only one valid: it wins.
  - Neither valid: no accept, and stage A becomes empty next cycle.
  - Both valid: resolved per the optional feature below.
- Reset mid-operation:
  - A command in stage A is dropped, with no memory write and no response.
  - Accepting resumes on the first edge after deassertion.
- Address wrap: no arithmetic on addresses; 0xFF is an ordinary address.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit rr pointer names the preferred requester.
  - On a contention cycle, the preferred requester wins and the pointer flips to the loser.
  - On an uncontended accept, the pointer is set to the requester not granted.
  - Both requesters continuously valid therefore alternate 0,1,0,1...
- Not defined:
  - Fixed priority: requester 0 always wins contention, so requester 1 can starve.
  - No pointer register exists.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream with a write to addr 0x10 in stage A -> o_mem_rw falls to 0 immediately, mem[0x10] unchanged, no rsp pulse, all outputs at reset values.
- Single read: req0 read addr 0x03 with mem[0x03]=125 -> o_req0_ready=1 same cycle; o_rsp0_valid one-cycle pulse 2 edges later with data 125; o_rsp1_valid stays 0.
- Write-then-read back-to-back: req1 write addr 0x20 data 0xBEEF, next cycle req1 read 0x20 -> write response echoes 0xBEEF; read response 1 cycle later returns 0xBEEF; one access per cycle, no bubble.
- Contention: both valid for 4 cycles, req0 reading 0x00–0x03 and req1 reading 0x04–0x07 -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it, req0 gets all 4 grants and req1 ready stays 0.
- Idle gap: a single accept followed by 3 idle cycles -> o_mem_rw=0 throughout the idle cycles, exactly one rsp pulse, no spurious writes (memory checksum unchanged).
